// File: rtl/nipcb_pkg.sv
// Shared types and constants for the neural-interface SPI arbiter.
package nipcb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT_LO = 3'd2,
        ST_WAIT_HI = 3'd3,
        ST_GUARD   = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWN_STIM = 1'b0,
        OWN_REC  = 1'b1
    } arb_owner_t;

    localparam int SPI_O_BW   = 16;
    localparam int SPI_I_BW   = 14;
    localparam int SLV_HP_DAC = 0;
    localparam int SLV_ADC    = 1;

    localparam logic [1:0] HP_DAC_MODE_NORMAL = 2'b00;
    localparam logic [7:0] MAG_NEUTRAL        = 8'h7F;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    // DAC frame as shifted out by spi_core: leading zero, mode+magnitude, five pad bits.
    function automatic logic [SPI_O_BW-1:0] dac_frame(input logic [9:0] tdata);
        return {1'b0, tdata, 5'b0_0000};
    endfunction

endpackage

// File: rtl/nipcb_spi_arbiter.sv
// Shares the neural-interface SPI master between the stimulation DAC and recording ADC paths.
// Optional NIPCB_ARB_STARVE_EN enables the anti-starvation forced recording grant.
module nipcb_spi_arbiter
    import nipcb_pkg::*;
#(
    parameter int GUARD_CYCLES = 4,
    parameter int STARVE_MAX   = 8,
    parameter int WDOG_CYCLES  = 3
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                stim_req,
    input  logic [9:0]          stim_tdata,
    input  logic                stim_lock,
    output logic                stim_grant,
    output logic                stim_done,
    input  logic                rec_req,
    output logic                rec_grant,
    output logic                rec_done,
    output logic [SPI_I_BW-1:0] rec_rdata,
    output logic [SPI_O_BW-1:0] spi_odata,
    output logic [1:0]          spi_send,
    output logic [1:0]          spi_recv,
    input  logic [SPI_I_BW-1:0] spi_idata,
    input  logic                spi_ready,
    output logic                arb_busy,
    output logic                arb_err
);

    localparam int GW = cnt_width(GUARD_CYCLES);
    localparam int WW = cnt_width(WDOG_CYCLES);
    localparam arb_state_t DONE_STATE = (GUARD_CYCLES == 0) ? ST_IDLE : ST_GUARD;

    arb_state_t          state_r, state_s;
    arb_owner_t          owner_r, owner_s;
    logic [WW-1:0]       wd_cnt_r, wd_cnt_s;
    logic [GW-1:0]       guard_cnt_r, guard_cnt_s;
    logic                stim_grant_r, stim_grant_s;
    logic                stim_done_r, stim_done_s;
    logic                rec_grant_r, rec_grant_s;
    logic                rec_done_r, rec_done_s;
    logic [SPI_I_BW-1:0] rec_rdata_r, rec_rdata_s;
    logic [SPI_O_BW-1:0] spi_odata_r, spi_odata_s;
    logic [1:0]          spi_send_r, spi_send_s;
    logic [1:0]          spi_recv_r, spi_recv_s;
    logic                arb_busy_r, arb_busy_s;
    logic                arb_err_r, arb_err_s;
    logic                rec_ok_s, rec_win_s, force_rec_s;

    assign rec_ok_s   = rec_req & ~stim_lock;
    assign rec_win_s  = rec_ok_s & (~stim_req | force_rec_s);
    assign arb_busy_s = (state_s != ST_IDLE);

`ifdef NIPCB_ARB_STARVE_EN
    localparam int SW = cnt_width(STARVE_MAX);
    logic [SW-1:0] starve_cnt_r;

    assign force_rec_s = (starve_cnt_r == SW'(STARVE_MAX));

    // Count stim grants issued while recording waits; a rec grant or an idle rec request clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (!rec_req) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (state_r == ST_ISSUE && owner_r == OWN_REC) begin
            starve_cnt_r <= {SW{1'b0}};
        end else if (state_r == ST_ISSUE && starve_cnt_r != SW'(STARVE_MAX)) begin
            starve_cnt_r <= starve_cnt_r + SW'(1);
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end
`else
    assign force_rec_s = 1'b0;
`endif

    // Next-state and next-output decode; every output is registered one edge later.
    always_comb begin
        state_s      = state_r;
        owner_s      = owner_r;
        wd_cnt_s     = wd_cnt_r;
        guard_cnt_s  = guard_cnt_r;
        stim_grant_s = 1'b0;
        stim_done_s  = 1'b0;
        rec_grant_s  = 1'b0;
        rec_done_s   = 1'b0;
        spi_send_s   = 2'b00;
        spi_recv_s   = 2'b00;
        rec_rdata_s  = rec_rdata_r;
        spi_odata_s  = spi_odata_r;
        arb_err_s    = arb_err_r;

        case (state_r)
            ST_IDLE: begin
                if (spi_ready && (stim_req || rec_ok_s)) begin
                    state_s = ST_ISSUE;
                    owner_s = rec_win_s ? OWN_REC : OWN_STIM;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_ISSUE: begin
                if (owner_r == OWN_REC) begin
                    spi_recv_s[SLV_ADC] = 1'b1;
                    rec_grant_s         = 1'b1;
                end else begin
                    spi_send_s[SLV_HP_DAC] = 1'b1;
                    stim_grant_s           = 1'b1;
                    spi_odata_s            = dac_frame(stim_tdata);
                end
                wd_cnt_s = {WW{1'b0}};
                state_s  = ST_WAIT_LO;
            end

            ST_WAIT_LO: begin
                if (!spi_ready) begin
                    state_s = ST_WAIT_HI;
                end else if (wd_cnt_r == WW'(WDOG_CYCLES - 1)) begin
                    // spi_core never started: flag it and release the owner anyway
                    arb_err_s   = 1'b1;
                    stim_done_s = (owner_r == OWN_STIM);
                    rec_done_s  = (owner_r == OWN_REC);
                    guard_cnt_s = GW'(GUARD_CYCLES);
                    state_s     = DONE_STATE;
                end else begin
                    wd_cnt_s = wd_cnt_r + WW'(1);
                end
            end

            ST_WAIT_HI: begin
                if (spi_ready) begin
                    if (owner_r == OWN_REC) begin
                        rec_done_s  = 1'b1;
                        rec_rdata_s = spi_idata;
                    end else begin
                        stim_done_s = 1'b1;
                    end
                    guard_cnt_s = GW'(GUARD_CYCLES);
                    state_s     = DONE_STATE;
                end else begin
                    state_s = ST_WAIT_HI;
                end
            end

            ST_GUARD: begin
                if (guard_cnt_r <= GW'(1)) begin
                    guard_cnt_s = {GW{1'b0}};
                    state_s     = ST_IDLE;
                end else begin
                    guard_cnt_s = guard_cnt_r - GW'(1);
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWN_STIM;
            wd_cnt_r     <= {WW{1'b0}};
            guard_cnt_r  <= {GW{1'b0}};
            stim_grant_r <= 1'b0;
            stim_done_r  <= 1'b0;
            rec_grant_r  <= 1'b0;
            rec_done_r   <= 1'b0;
            rec_rdata_r  <= {SPI_I_BW{1'b0}};
            spi_odata_r  <= {SPI_O_BW{1'b0}};
            spi_send_r   <= 2'b00;
            spi_recv_r   <= 2'b00;
            arb_busy_r   <= 1'b0;
            arb_err_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            owner_r      <= owner_s;
            wd_cnt_r     <= wd_cnt_s;
            guard_cnt_r  <= guard_cnt_s;
            stim_grant_r <= stim_grant_s;
            stim_done_r  <= stim_done_s;
            rec_grant_r  <= rec_grant_s;
            rec_done_r   <= rec_done_s;
            rec_rdata_r  <= rec_rdata_s;
            spi_odata_r  <= spi_odata_s;
            spi_send_r   <= spi_send_s;
            spi_recv_r   <= spi_recv_s;
            arb_busy_r   <= arb_busy_s;
            arb_err_r    <= arb_err_s;
        end
    end

    assign stim_grant = stim_grant_r;
    assign stim_done  = stim_done_r;
    assign rec_grant  = rec_grant_r;
    assign rec_done   = rec_done_r;
    assign rec_rdata  = rec_rdata_r;
    assign spi_odata  = spi_odata_r;
    assign spi_send   = spi_send_r;
    assign spi_recv   = spi_recv_r;
    assign arb_busy   = arb_busy_r;
    assign arb_err    = arb_err_r;

endmodule

// File: tb/tb_nipcb_spi_arbiter.sv
// Directed bench for nipcb_spi_arbiter: transaction-level reference model, per-cycle compare,
// and a behavioural spi_core responder.
`timescale 1ns/1ps
module tb_nipcb_spi_arbiter;
    import nipcb_pkg::*;

    localparam int GUARD  = 4;
    localparam int STARVE = 8;
    localparam int WDOG   = 3;
    localparam int XFER   = 5;
`ifdef NIPCB_ARB_STARVE_EN
    localparam logic EXP9_REC = 1'b1;
    localparam int   EXP_NST  = 8;
`else
    localparam logic EXP9_REC = 1'b0;
    localparam int   EXP_NST  = 9;
`endif

    logic        clk;
    logic        rstn;
    logic        stim_req, stim_lock, rec_req;
    logic [9:0]  stim_tdata;
    logic        stim_grant, stim_done, rec_grant, rec_done;
    logic [13:0] rec_rdata, spi_idata;
    logic [15:0] spi_odata;
    logic [1:0]  spi_send, spi_recv;
    logic        spi_ready, arb_busy, arb_err;

    logic        spi_stuck = 1'b0;
    logic        spi_hang  = 1'b0;
    logic [13:0] adc_word  = 14'h0;

    int n_vec = 0;
    int n_err = 0;

    logic        exp_stim_grant = 1'b0, exp_stim_done = 1'b0;
    logic        exp_rec_grant = 1'b0, exp_rec_done = 1'b0;
    logic [1:0]  exp_send = 2'b00, exp_recv = 2'b00;
    logic [15:0] exp_odata = 16'h0;
    logic [13:0] exp_rdata = 14'h0;
    logic        exp_busy = 1'b0, exp_err = 1'b0;
    int          m_starve = 0;

    nipcb_spi_arbiter #(
        .GUARD_CYCLES(GUARD), .STARVE_MAX(STARVE), .WDOG_CYCLES(WDOG)
    ) dut (
        .clk(clk), .rstn(rstn),
        .stim_req(stim_req), .stim_tdata(stim_tdata), .stim_lock(stim_lock),
        .stim_grant(stim_grant), .stim_done(stim_done),
        .rec_req(rec_req), .rec_grant(rec_grant), .rec_done(rec_done), .rec_rdata(rec_rdata),
        .spi_odata(spi_odata), .spi_send(spi_send), .spi_recv(spi_recv),
        .spi_idata(spi_idata), .spi_ready(spi_ready),
        .arb_busy(arb_busy), .arb_err(arb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // spi_core stand-in: a send/recv pulse drops ready for XFER cycles, then returns adc_word.
    initial begin
        spi_ready = 1'b1;
        spi_idata = 14'h0;
        forever begin
            @(negedge clk);
            if (!spi_stuck && (spi_send != 2'b00 || spi_recv != 2'b00)) begin
                spi_ready = 1'b0;
                repeat (XFER) @(negedge clk);
                while (spi_hang) @(negedge clk);
                spi_idata = adc_word;
                spi_ready = 1'b1;
            end
        end
    end

    // Model clock step: pulses last one cycle, reset restores everything and aborts the transaction.
    task automatic tick(output bit ab);
        @(posedge clk);
        exp_stim_grant = 1'b0; exp_stim_done = 1'b0;
        exp_rec_grant  = 1'b0; exp_rec_done  = 1'b0;
        exp_send = 2'b00; exp_recv = 2'b00;
        ab = 1'b0;
        if (!rstn) begin
            exp_odata = 16'h0; exp_rdata = 14'h0;
            exp_busy = 1'b0; exp_err = 1'b0; m_starve = 0;
            ab = 1'b1;
        end else if (!rec_req) begin
            m_starve = 0;
        end
    endtask

    // One arbitration opportunity followed, when someone wins, by the whole transaction.
    task automatic model_step();
        bit ab, rec_wins, to, force_rec;
        int n;
        tick(ab);
        if (ab || !spi_ready) return;
`ifdef NIPCB_ARB_STARVE_EN
        force_rec = (m_starve == STARVE);
`else
        force_rec = 1'b0;
`endif
        if (rec_req && !stim_lock && (!stim_req || force_rec)) rec_wins = 1'b1;
        else if (stim_req) rec_wins = 1'b0;
        else return;
        exp_busy = 1'b1;
        tick(ab);
        if (ab) return;
        if (rec_wins) begin
            exp_rec_grant = 1'b1; exp_recv = 2'b10; m_starve = 0;
        end else begin
            exp_stim_grant = 1'b1; exp_send = 2'b01;
            exp_odata = {1'b0, stim_tdata, 5'b00000};
            if (rec_req && m_starve < STARVE) m_starve++;
        end
        n = 0;
        to = 1'b0;
        forever begin
            tick(ab);
            if (ab) return;
            if (!spi_ready) break;
            n++;
            if (n == WDOG) begin
                to = 1'b1;
                break;
            end
        end
        if (!to) begin
            forever begin
                tick(ab);
                if (ab) return;
                if (spi_ready) break;
            end
            if (rec_wins) exp_rdata = spi_idata;
        end else begin
            exp_err = 1'b1;
        end
        if (rec_wins) exp_rec_done = 1'b1;
        else exp_stim_done = 1'b1;
        if (GUARD == 0) exp_busy = 1'b0;
        for (int i = 1; i <= GUARD; i++) begin
            tick(ab);
            if (ab) return;
            if (i == GUARD) exp_busy = 1'b0;
        end
    endtask

    initial begin
        forever model_step();
    end

    // Every cycle, every output against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("stim_grant", 32'(stim_grant), 32'(exp_stim_grant));
            chk("stim_done", 32'(stim_done), 32'(exp_stim_done));
            chk("rec_grant", 32'(rec_grant), 32'(exp_rec_grant));
            chk("rec_done", 32'(rec_done), 32'(exp_rec_done));
            chk("rec_rdata", 32'(rec_rdata), 32'(exp_rdata));
            chk("spi_odata", 32'(spi_odata), 32'(exp_odata));
            chk("spi_send", 32'(spi_send), 32'(exp_send));
            chk("spi_recv", 32'(spi_recv), 32'(exp_recv));
            chk("arb_busy", 32'(arb_busy), 32'(exp_busy));
            chk("arb_err", 32'(arb_err), 32'(exp_err));
        end
    end

    function automatic logic probe(input int s);
        case (s)
            0:       return stim_grant;
            1:       return stim_done;
            2:       return rec_grant;
            3:       return rec_done;
            4:       return !arb_busy;
            5:       return stim_grant | rec_grant;
            6:       return stim_done | rec_done;
            default: return 1'b0;
        endcase
    endfunction

    // Bounded wait for an output event; cyc counts falling edges until it is seen.
    task automatic wait_for(input int s, input string name, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!probe(s) && cyc < 200);
        n_vec++;
        if (!probe(s)) begin
            n_err++;
            $display("FAIL %s: event not seen within %0d cycles", name, cyc);
        end
    endtask

    initial begin
        int c, cnt, nst;
        rstn = 1'b0; stim_req = 1'b0; stim_tdata = 10'h0; stim_lock = 1'b0; rec_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(arb_busy), 32'h0);
        chk("rst_odata", 32'(spi_odata), 32'h0);
        chk("rst_rdata", 32'(rec_rdata), 32'h0);
        chk("rst_err", 32'(arb_err), 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        // Lone stimulation request
        stim_tdata = 10'h0FF; stim_req = 1'b1;
        wait_for(0, "stim_grant_wait", c);
        chk("stim_grant_latency", 32'(c), 32'd2);
        chk("stim_odata", 32'(spi_odata), 32'h1FE0);
        chk("stim_send", 32'(spi_send), 32'h1);
        chk("stim_recv", 32'(spi_recv), 32'h0);
        @(negedge clk);
        chk("stim_send_pulse", 32'(spi_send), 32'h0);
        wait_for(1, "stim_done_wait", c);
        stim_req = 1'b0;
        // rec request withdrawn while still in guard must never be granted
        rec_req = 1'b1;
        @(negedge clk);
        rec_req = 1'b0;
        wait_for(4, "stim_idle_wait", c);
        chk("busy_low_after_done", 32'(c + 1), 32'(GUARD));
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (rec_grant) cnt++;
        end
        chk("dropped_req_no_grant", 32'(cnt), 32'h0);

        // Lone recording request
        adc_word = 14'h2A5A; rec_req = 1'b1;
        wait_for(2, "rec_grant_wait", c);
        chk("rec_grant_latency", 32'(c), 32'd2);
        chk("rec_recv", 32'(spi_recv), 32'h2);
        chk("rec_send", 32'(spi_send), 32'h0);
        wait_for(3, "rec_done_wait", c);
        chk("rec_rdata_val", 32'(rec_rdata), 32'h2A5A);
        rec_req = 1'b0;
        wait_for(4, "rec_idle_wait", c);

        // Simultaneous requests held across nine grants
        adc_word = 14'h1234; stim_tdata = 10'h155; stim_req = 1'b1; rec_req = 1'b1;
        nst = 0;
        for (int i = 1; i <= 9; i++) begin
            wait_for(5, "both_grant_wait", c);
            if (stim_grant) nst++;
            if (i == 1) begin
                chk("first_grant_stim", 32'(stim_grant), 32'h1);
                chk("first_grant_odata", 32'(spi_odata), 32'h2AA0);
            end
            if (i == 9) chk("ninth_grant_rec", 32'(rec_grant), 32'(EXP9_REC));
            wait_for(6, "both_done_wait", c);
        end
        chk("stim_grant_count", 32'(nst), 32'(EXP_NST));
        stim_req = 1'b0; rec_req = 1'b0;
        wait_for(4, "both_idle_wait", c);

        // Lockout, release, then lock rising during the read
        adc_word = 14'h0F0F; stim_lock = 1'b1; rec_req = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (rec_grant) cnt++;
        end
        chk("lockout_no_grant", 32'(cnt), 32'h0);
        stim_lock = 1'b0;
        wait_for(2, "unlock_grant_wait", c);
        chk("unlock_grant_latency", 32'(c), 32'd2);
        stim_lock = 1'b1;
        wait_for(3, "locked_read_done", c);
        chk("locked_read_data", 32'(rec_rdata), 32'h0F0F);
        rec_req = 1'b0; stim_lock = 1'b0;
        wait_for(4, "lock_idle_wait", c);

        // Watchdog: spi_core never drops ready
        spi_stuck = 1'b1;
        stim_tdata = {HP_DAC_MODE_NORMAL, MAG_NEUTRAL}; stim_req = 1'b1;
        wait_for(0, "wdog_grant_wait", c);
        chk("wdog_odata", 32'(spi_odata), 32'h0FE0);
        chk("wdog_err_before", 32'(arb_err), 32'h0);
        wait_for(1, "wdog_done_wait", c);
        chk("wdog_latency", 32'(c), 32'(WDOG));
        chk("wdog_err_set", 32'(arb_err), 32'h1);
        stim_req = 1'b0; spi_stuck = 1'b0;
        wait_for(4, "wdog_idle_wait", c);
        adc_word = 14'h3C3C; rec_req = 1'b1;
        wait_for(3, "post_wdog_done", c);
        chk("post_wdog_rdata", 32'(rec_rdata), 32'h3C3C);
        chk("wdog_err_sticky", 32'(arb_err), 32'h1);
        rec_req = 1'b0;
        wait_for(4, "post_wdog_idle", c);

        // Reset while waiting for ready to return
        spi_hang = 1'b1; adc_word = 14'h1111; rec_req = 1'b1;
        wait_for(2, "rst_grant_wait", c);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 32'(arb_busy), 32'h1);
        rstn = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy", 32'(arb_busy), 32'h0);
        chk("mid_rst_done", 32'(rec_done), 32'h0);
        chk("mid_rst_rdata", 32'(rec_rdata), 32'h0);
        chk("mid_rst_odata", 32'(spi_odata), 32'h0);
        chk("mid_rst_err", 32'(arb_err), 32'h0);
        rstn = 1'b1; rec_req = 1'b0; spi_hang = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (rec_done || stim_done) cnt++;
        end
        chk("no_done_after_rst", 32'(cnt), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
